// File: rtl/prbs_pkg.sv
// prbs_pkg: shared state encoding and default parameters for the PRBS checker.
package prbs_pkg;

    typedef enum logic [1:0] {FILL, SYNC, LOCKED} state_e;

    localparam int DEF_LFSR_WIDTH    = 10;
    localparam int DEF_TAP_A         = 10;
    localparam int DEF_TAP_B         = 7;
    localparam int DEF_LOCK_COUNT    = 16;
    localparam int DEF_UNLOCK_ERRORS = 4;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with a synchronous clear that beats increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising checker for the x^10+x^7+1 LFSR bitstream;
// locks after a clean run and counts bit errors while locked.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int LFSR_WIDTH    = DEF_LFSR_WIDTH,
    parameter int TAP_A         = DEF_TAP_A,
    parameter int TAP_B         = DEF_TAP_B,
    parameter int LOCK_COUNT    = DEF_LOCK_COUNT,
    parameter int UNLOCK_ERRORS = DEF_UNLOCK_ERRORS,
    parameter int ERR_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clear_errors,
    output logic             locked,
    output logic             error_pulse,
    output logic [ERR_W-1:0] error_count
);

    localparam int FW = $clog2(LFSR_WIDTH + 1);
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(UNLOCK_ERRORS + 1);

    state_e              state_q, state_d;
    logic [LFSR_WIDTH:1] sr_q, sr_d;
    logic [FW-1:0]       fill_q, fill_d;
    logic [CW-1:0]       run_q, run_d;
    logic [BW-1:0]       bad_q, bad_d;
    logic                pulse_q, pulse_d;
    logic                mis;

    assign mis = bit_in ^ sr_q[TAP_A] ^ sr_q[TAP_B];

    // run_q counts consecutive matches in SYNC and the clean run in LOCKED
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        fill_d  = fill_q;
        run_d   = run_q;
        bad_d   = bad_q;
        pulse_d = 1'b0;
        if (bit_valid) begin
            sr_d = {sr_q[LFSR_WIDTH-1:1], bit_in};
            case (state_q)
                FILL: begin
                    fill_d = fill_q + 1'b1;
                    if (fill_q == FW'(LFSR_WIDTH - 1)) begin
                        state_d = SYNC;
                        run_d   = '0;
                    end
                end
                SYNC: begin
                    if (mis || sr_d == '0) begin
                        run_d = '0;
                    end else if (run_q == CW'(LOCK_COUNT - 1)) begin
                        state_d = LOCKED;
                        run_d   = '0;
                        bad_d   = '0;
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (mis) begin
                        pulse_d = 1'b1;
                        run_d   = '0;
                        if (bad_q == BW'(UNLOCK_ERRORS - 1)) begin
                            state_d = SYNC;
                            bad_d   = '0;
                        end else begin
                            bad_d = bad_q + 1'b1;
                        end
                    end else if (run_q == CW'(LOCK_COUNT - 1)) begin
                        run_d = '0;
                        bad_d = '0;
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            sr_q    <= '0;
            fill_q  <= '0;
            run_q   <= '0;
            bad_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            fill_q  <= fill_d;
            run_q   <= run_d;
            bad_q   <= bad_d;
            pulse_q <= pulse_d;
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clear_errors),
        .inc_i (pulse_d),
        .cnt_o (error_count)
    );

    assign locked      = (state_q == LOCKED);
    assign error_pulse = pulse_q;

endmodule
